// File: rtl/lfsr_rand_gen_if.sv
// Output stream of lfsr_rand_gen: one registered random value plus valid/ready.
// Latency: none; this only bundles the signals.
// Backpressure: the value holds while rand_valid=1 and rand_ready=0.
//   rand_out   : random value in 0..RANGE-1 (producer -> consumer)
//   rand_valid : rand_out holds an unconsumed value (producer -> consumer)
//   rand_ready : consumer accepts rand_out when rand_valid=1 (consumer -> producer)
interface lfsr_rand_gen_if #(
  parameter int OUT_W = 4
);
  logic [OUT_W-1:0] rand_out;
  logic             rand_valid;
  logic             rand_ready;

  modport master (output rand_out, output rand_valid, input rand_ready);
  modport slave  (input rand_out, input rand_valid, output rand_ready);
endinterface

// File: rtl/lfsr_rand_gen.sv
// Bounded-range random number source built on a free-running Galois LFSR.
// Latency: rand_valid rises 1..MAX_TRIES edges after entering DRAW with en=1.
// Backpressure: a value holds until rand_valid&rand_ready; the LFSR keeps running regardless.
// Ports:
//   clk, rst_n   : clock (rising edge) and asynchronous active-low reset
//   en           : draw enable; 0 pauses acceptance and holds the try counter
//   seed_load    : load seed_in into the LFSR this edge (0 maps to SEED)
//   seed_in      : seed value
//   rand_if      : master side of the rand_out/rand_valid/rand_ready stream
//   fallback_cnt : saturating count of draws resolved by the fallback value
module lfsr_rand_gen #(
  parameter int WIDTH     = 8,
  parameter int RANGE     = 9,
  parameter int SEED      = 1,
  parameter int NO_REPEAT = 1,
  parameter int MAX_TRIES = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              seed_load,
  input  logic [WIDTH-1:0]  seed_in,
  lfsr_rand_gen_if.master   rand_if,
  output logic [7:0]        fallback_cnt
);

  localparam int OUT_W = ($clog2(RANGE) < 1) ? 1 : $clog2(RANGE);
  localparam int TRY_W = ($clog2(MAX_TRIES + 1) < 1) ? 1 : $clog2(MAX_TRIES + 1);

  // Maximal-length feedback masks for a right-shifting Galois LFSR.
  function automatic logic [15:0] taps_for(input int w);
    logic [15:0] t;
    case (w)
      4:       t = 16'h000C;
      5:       t = 16'h0014;
      6:       t = 16'h0030;
      7:       t = 16'h0060;
      8:       t = 16'h00B8;
      9:       t = 16'h0110;
      10:      t = 16'h0240;
      11:      t = 16'h0500;
      12:      t = 16'h0E08;
      13:      t = 16'h1C80;
      14:      t = 16'h3802;
      15:      t = 16'h6000;
      16:      t = 16'hD008;
      default: t = 16'h00B8;
    endcase
    return t;
  endfunction

  localparam logic [15:0]      TAPS16   = taps_for(WIDTH);
  localparam logic [WIDTH-1:0] TAPS     = TAPS16[WIDTH-1:0];
  localparam logic [WIDTH-1:0] SEED_V   = WIDTH'(SEED);
  // One bit wider than a value so RANGE = 2^OUT_W still compares correctly.
  localparam logic [OUT_W:0]   RANGE_W  = (OUT_W + 1)'(RANGE);
  localparam logic [TRY_W-1:0] TRY_LAST = TRY_W'(MAX_TRIES - 1);

  typedef enum logic {S_DRAW, S_HOLD} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] lfsr_q, lfsr_d;
  logic [OUT_W-1:0] rand_out_q, rand_out_d;
  logic             rand_valid_q, rand_valid_d;
  logic [OUT_W-1:0] last_q, last_d;
  logic             last_vld_q, last_vld_d;
  logic [TRY_W-1:0] tries_q, tries_d;
  logic [7:0]       fb_cnt_q, fb_cnt_d;

  logic [OUT_W-1:0] cand;
  logic             cand_ok;
  logic [OUT_W-1:0] fb_val;

  always_comb begin
    // The LFSR advances every cycle; seed_load replaces the advance, and a
    // draw on the same edge still sees lfsr_q (the pre-load value).
    lfsr_d = lfsr_q[0] ? ((lfsr_q >> 1) ^ TAPS) : (lfsr_q >> 1);
    if (seed_load) begin
      lfsr_d = (seed_in == '0) ? SEED_V : seed_in;
    end

    cand    = lfsr_q[OUT_W-1:0];
    cand_ok = ({1'b0, cand} < RANGE_W) &&
              ((NO_REPEAT == 0) || !last_vld_q || (cand != last_q));

    fb_val = '0;
    if (last_vld_q) begin
      fb_val = (({1'b0, last_q} + 1'b1) == RANGE_W) ? '0 : (last_q + 1'b1);
    end

    state_d      = state_q;
    rand_out_d   = rand_out_q;
    rand_valid_d = rand_valid_q;
    last_d       = last_q;
    last_vld_d   = last_vld_q;
    tries_d      = tries_q;
    fb_cnt_d     = fb_cnt_q;

    case (state_q)
      S_DRAW: begin
        if (en) begin
          if (cand_ok) begin
            rand_out_d   = cand;
            last_d       = cand;
            last_vld_d   = 1'b1;
            rand_valid_d = 1'b1;
            tries_d      = '0;
            state_d      = S_HOLD;
          end else if (tries_q == TRY_LAST) begin
            // This rejection would exhaust the budget: emit the fallback.
            rand_out_d   = fb_val;
            last_d       = fb_val;
            last_vld_d   = 1'b1;
            rand_valid_d = 1'b1;
            tries_d      = '0;
            state_d      = S_HOLD;
            if (fb_cnt_q != 8'hFF) begin
              fb_cnt_d = fb_cnt_q + 8'd1;
            end
          end else begin
            tries_d = tries_q + 1'b1;
          end
        end
      end
      S_HOLD: begin
        if (rand_valid_q && rand_if.rand_ready) begin
          rand_valid_d = 1'b0;
          state_d      = S_DRAW;
        end
      end
      default: state_d = S_DRAW;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_DRAW;
      lfsr_q       <= SEED_V;
      rand_out_q   <= '0;
      rand_valid_q <= 1'b0;
      last_q       <= '0;
      last_vld_q   <= 1'b0;
      tries_q      <= '0;
      fb_cnt_q     <= 8'd0;
    end else begin
      state_q      <= state_d;
      lfsr_q       <= lfsr_d;
      rand_out_q   <= rand_out_d;
      rand_valid_q <= rand_valid_d;
      last_q       <= last_d;
      last_vld_q   <= last_vld_d;
      tries_q      <= tries_d;
      fb_cnt_q     <= fb_cnt_d;
    end
  end

  assign rand_if.rand_out   = rand_out_q;
  assign rand_if.rand_valid = rand_valid_q;
  assign fallback_cnt       = fb_cnt_q;

endmodule

// File: doc/lfsr_rand_gen.md
LFSR_RAND_GEN -- requirements
Module: lfsr_rand_gen

Interface
REQ-001 SHALL have parameter WIDTH, default 8, LFSR width; legal 4..16.
REQ-002 SHALL have parameter RANGE, default 9, output values span 0..RANGE-1; legal 2..2^(WIDTH-1).
REQ-003 SHALL have parameter SEED, default 1, reset/fallback LFSR value; nonzero.
REQ-004 SHALL have parameter NO_REPEAT, default 1, forbids two consecutive equal outputs when 1.
REQ-005 SHALL have parameter MAX_TRIES, default 8, rejected draws before fallback.
REQ-006 SHALL have derived local OUT_W = max(1, clog2(RANGE)).
REQ-007 clk  input  1  single clock, all state on rising edge.
REQ-008 rst_n  input  1  asynchronous active-low reset.
REQ-009 en  input  1  draw enable; 0 stalls acceptance, LFSR keeps running.
REQ-010 seed_load  input  1  loads seed_in into LFSR on this edge.
REQ-011 seed_in  input  WIDTH  seed value.
REQ-012 rand_ready  input  1  consumer accepts rand_out when rand_valid=1.
REQ-013 rand_out  output  OUT_W  registered random value.
REQ-014 rand_valid  output  1  rand_out holds an unconsumed value.
REQ-015 fallback_cnt  output  8  saturating count of fallback draws.

Function
REQ-016 LFSR SHALL be Galois, right-shift: if lfsr[0] then lfsr=(lfsr>>1)^TAPS else lfsr>>1, advancing every cycle; TAPS from maximal-length table (WIDTH=8: 8'hB8).
REQ-017 seed_load SHALL load seed_in instead of advancing; seed_in=0 loads SEED (no lock-up); a draw on the same edge samples the pre-load LFSR value.
REQ-018 FSM states SHALL be DRAW and HOLD; reset state DRAW.
REQ-019 In DRAW with en=1, candidate = lfsr[OUT_W-1:0] sampled each edge; accept iff candidate<RANGE and (NO_REPEAT=0 or no prior value or candidate!=last).
REQ-020 On accept: rand_out<=candidate, last<=candidate, rand_valid<=1, tries<=0, state->HOLD.
REQ-021 On reject: tries+1; when the rejection would make tries=MAX_TRIES, SHALL instead accept fallback (last+1) mod RANGE (0 if no prior value), increment fallback_cnt (saturate at 255), go HOLD.
REQ-022 Latency: rand_valid SHALL rise 1..MAX_TRIES cycles after entering DRAW with en=1.
REQ-023 In DRAW with en=0: no acceptance, tries held.
REQ-024 In HOLD: rand_out and rand_valid stable; on rand_valid&rand_ready, rand_valid<=0 and state->DRAW (one bubble cycle minimum between values).
REQ-025 en deasserting in HOLD SHALL NOT drop rand_valid.
REQ-026 rand_ready while rand_valid=0 SHALL be ignored.

Reset
REQ-027 rst_n=0 SHALL immediately force lfsr=SEED, rand_out=0, rand_valid=0, last invalid, tries=0, fallback_cnt=0, state DRAW, regardless of clk.
REQ-028 Reset mid-HOLD SHALL discard the pending value; no handshake completes.

Verification (defaults WIDTH=8, RANGE=9, SEED=1)
REQ-029 Release reset, en=1, rand_ready=0 -> after edge 1 rand_valid=1, rand_out=1, held indefinitely.
REQ-030 Then rand_ready=1 from edge 2 -> handshake at edge 2; edges 3,4 reject (lfsr 5C->12, 2E->14); edge 5 accepts 7; rand_valid=1 after edge 5.
REQ-031 NO_REPEAT=1, 10000 handshakes -> all values in 0..8, no consecutive duplicates, every value seen.
REQ-032 MAX_TRIES=1, seed forcing candidate >=9 -> fallback (last+1) mod 9 produced, fallback_cnt increments.
REQ-033 seed_load=1, seed_in=0 -> lfsr=8'h01 next edge; seed_in=8'hA5 -> lfsr=8'hA5.
REQ-034 Assert rst_n=0 between clock edges while rand_valid=1 -> rand_valid, rand_out go 0 immediately.
